mu_mem_arbiter: RTL
===================

Name: mu_mem_arbiter

Overview:
- Two-port arbiter/sequencer in front of the single-port data RAM of the multicycle MIPS core.
- Port 0 is the instruction-fetch path (read-only). Port 1 is the load/store path (read/write).
- Serialises accesses, range-checks addresses against the RAM window, drives the RAM address/data/write-enable, and returns registered read data with a done/err handshake.

Parameters:
- DATA_WIDTH, 32, width of addresses and data.
- BASE_ADDR, 32'h10010000, byte address of RAM word 0.
- DEPTH, 64, number of RAM words; valid window is [BASE_ADDR, BASE_ADDR+4*DEPTH).
- FIXED_PRIO, 0; 0 = round-robin, 1 = port 1 always wins ties.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  fetch request; held until p0_done.
- p0_addr  in  DATA_WIDTH  fetch byte address.
- p0_done  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_WIDTH  fetched word, valid when p0_done=1.
- p0_err  out  1  with p0_done: out-of-window or misaligned address.
- p1_req  in  1  data request; held until p1_done.
- p1_we  in  1  1 = store, 0 = load.
- p1_addr  in  DATA_WIDTH  data byte address.
- p1_wdata  in  DATA_WIDTH  store data.
- p1_done  out  1  one-cycle completion pulse.
- p1_rdata  out  DATA_WIDTH  load data, valid when p1_done=1.
- p1_err  out  1  with p1_done: bad address; store suppressed.
- ram_addr  out  DATA_WIDTH  byte address to RAM.
- ram_wdata  out  DATA_WIDTH  write data to RAM.
- ram_we  out  1  RAM write enable.
- ram_q  in  DATA_WIDTH  RAM combinational read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (rst=1 at a clock edge, in any state, including mid-transaction):
  - State goes to IDLE.
  - All done/err/ram_we/busy = 0; p0_rdata = p1_rdata = ram_wdata = 0; ram_addr = BASE_ADDR.
  - Round-robin pointer is set to favour port 1 first.
  - An in-flight transaction is dropped; no done pulse is issued for it.
- IDLE, at least one req high:
  - Arbitrate: with one requester, grant it. With both and FIXED_PRIO=0, grant the port not served last. With both and FIXED_PRIO=1, grant port 1.
  - Latch the granted port's addr, we (port 0 forces we=0) and wdata, plus the grant id.
  - Compute bad = (addr < BASE_ADDR) or (addr >= BASE_ADDR+4*DEPTH) or (addr[1:0] != 0). Use full-width unsigned compare; the upper bound is computed without overflow.
  - Go to ACCESS.
- ACCESS:
  - ram_addr = latched addr. ram_wdata = latched wdata.
  - ram_we = latched we AND NOT bad, for exactly this one cycle.
  - On exit, capture ram_q into the granted port's rdata; rdata is 0 if bad or if the access is a write.
  - Go to RESP.
- RESP:
  - Granted port's done=1 for exactly one cycle; err=bad.
  - Update the round-robin pointer to the served port. Go to IDLE.
- Latency and throughput:
  - req sampled in cycle N gives done in cycle N+2.
  - One transaction per 3 cycles maximum.
  - done and err are registered outputs, low except in RESP.
- Handshake rules:
  - A requester holds req stable until it sees its done, then drops req on the following edge unless it has a new request.
  - addr/wdata/we changes after grant are ignored.
  - A req deasserted after grant does not cancel the transaction; done still pulses.
  - The ungranted port waits; its req stays pending with no loss.
- rdata holds its last value between transactions, and is updated only for the granted port.
- ram_addr is held at the last access address outside ACCESS. ram_we is 0 outside ACCESS.

Test Plan:
- Reset then single fetch: p0_req=1, p0_addr=32'h10010008, RAM word 2=32'hDEADBEEF -> p0_done at cycle+2, p0_rdata=32'hDEADBEEF, p0_err=0, ram_we never 1.
- Store then load: p1_we=1, addr 32'h100100FC, wdata 32'hA5A5_0001 -> ram_we high for exactly one cycle with ram_addr=32'h100100FC; then a load at the same addr returns 32'hA5A50001.
- Contention, round-robin: p0_req and p1_req both held continuously from reset -> grant order p1, p0, p1, p0; done pulses 3 cycles apart. With FIXED_PRIO=1, port 1 is served every time while its req stays high.
- Bad addresses: p1 store to 32'h10010100 (one past end), 32'h1000FFFC, and 32'h10010002 -> p1_err=1 with p1_done, ram_we stays 0, RAM contents unchanged.
- Mid-transaction reset: assert rst in the ACCESS cycle of a store -> no done pulse, busy=0 next cycle, all outputs at reset values; a subsequent request completes normally.
- Stability: change p1_addr and p1_wdata one cycle after grant -> the write uses the originally latched values.

Source files
------------

// File: rtl/mu_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data RAM of the multicycle MIPS core.
// Port 0 is instruction fetch (read-only); port 1 is load/store. One access every 3 cycles.
module mu_mem_arbiter #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    BASE_ADDR  = 32'h10010000,
    parameter int unsigned              DEPTH      = 64,
    parameter bit                       FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic [DATA_WIDTH-1:0] p0_addr,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DATA_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // One extra bit so the window end cannot wrap for windows near the top of memory.
    localparam logic [DATA_WIDTH:0] LO_ADDR  = {1'b0, BASE_ADDR};
    localparam logic [DATA_WIDTH:0] END_ADDR = LO_ADDR + (DATA_WIDTH+1)'(4 * DEPTH);

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  rr_q, rr_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  bad_q, bad_d;
    logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
    logic                  p0_done_q, p0_done_d;
    logic                  p1_done_q, p1_done_d;
    logic                  p0_err_q, p0_err_d;
    logic                  p1_err_q, p1_err_d;

    logic                  pick1;
    logic [DATA_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH:0]   req_addr_x;
    logic [DATA_WIDTH-1:0] rd_val;

    // rr_q holds the port served last; port 1 wins a tie unless it was just served.
    assign pick1      = p1_req & (~p0_req | FIXED_PRIO | ~rr_q);
    assign req_addr   = pick1 ? p1_addr : p0_addr;
    assign req_addr_x = {1'b0, req_addr};
    assign rd_val     = (bad_q | we_q) ? '0 : ram_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        bad_d      = bad_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        p0_err_d   = 1'b0;
        p1_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (p0_req | p1_req) begin
                    gnt_d   = pick1;
                    addr_d  = req_addr;
                    we_d    = pick1 & p1_we;
                    wdata_d = pick1 ? p1_wdata : '0;
                    bad_d   = (req_addr_x < LO_ADDR) || (req_addr_x >= END_ADDR) ||
                              (req_addr[1:0] != 2'b00);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (gnt_q) begin
                    p1_rdata_d = rd_val;
                    p1_done_d  = 1'b1;
                    p1_err_d   = bad_q;
                end else begin
                    p0_rdata_d = rd_val;
                    p0_done_d  = 1'b1;
                    p0_err_d   = bad_q;
                end
                state_d = RESP;
            end
            RESP: begin
                rr_d    = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            rr_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            bad_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            bad_q      <= bad_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = (state_q == ACCESS) & we_q & ~bad_q;
    assign busy      = (state_q != IDLE);
    assign p0_done   = p0_done_q;
    assign p1_done   = p1_done_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule
